// File: rtl/arm_pkg.sv
// arm_pkg: shared writeback-stage types and constants for the LEGv8 datapath
// Contents: wb_state_t FSM encoding, XZR register index, data_t datapath word
package arm_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} wb_state_t;
    localparam logic [4:0] XZR = 5'd31;
    typedef logic [63:0] data_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage handshake, data-memory return and register-file write bus
// master: memory stage / dmem side, drives in_* and dmem_*, observes in_ready and write port
// slave:  wb_stage, drives in_ready, RegWrite, WriteRegister, WriteData, load_timeout_err
interface wb_stage_if #(parameter int DATA_W = 64);
    logic              in_valid;
    logic              in_ready;
    logic              in_RegWrite;
    logic              in_MemToReg;
    logic [4:0]        in_Rd;
    logic [DATA_W-1:0] in_ALUResult;
    logic              in_ByteLoad;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              load_timeout_err;
    modport master (
        output in_valid, in_RegWrite, in_MemToReg, in_Rd, in_ALUResult, in_ByteLoad,
        output dmem_rvalid, dmem_rdata,
        input  in_ready, RegWrite, WriteRegister, WriteData, load_timeout_err
    );
    modport slave (
        input  in_valid, in_RegWrite, in_MemToReg, in_Rd, in_ALUResult, in_ByteLoad,
        input  dmem_rvalid, dmem_rdata,
        output in_ready, RegWrite, WriteRegister, WriteData, load_timeout_err
    );
endinterface

// File: rtl/wb_stage_load_extend.sv
// load_extend: zero-extends the low byte of load data for LDURB, else passes it through
// Ports: i_byte (byte load select), i_rdata (raw load data), o_data (extended result)
// Built only when WB_BYTE_LOAD_EN is defined.
`ifdef WB_BYTE_LOAD_EN
module load_extend #(parameter int DATA_W = 64) (
    input  logic              i_byte,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data
);
    always_comb o_data = i_byte ? {{(DATA_W-8){1'b0}}, i_rdata[7:0]} : i_rdata;
endmodule
`endif

// File: rtl/wb_stage.sv
// wb_stage: LEGv8 writeback stage, one register-file write per retiring instruction
// Ports: clk, reset_n (sync, active-low), bus (wb_stage_if.slave: memory-stage
//   handshake in_*, load return dmem_*, register-file write port and sticky load_timeout_err)
// Option: WB_BYTE_LOAD_EN enables zero-extended byte loads via load_extend.
module wb_stage import arm_pkg::*; #(
    parameter int DATA_W       = 64,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    wb_stage_if.slave  bus
);
    localparam logic [7:0] LT_LAST = 8'(LOAD_TIMEOUT - 1);
    wb_state_t         r_state, w_next;
    logic [4:0]        r_rd;
    logic              r_we;
    logic [DATA_W-1:0] r_data, w_load;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              w_xfer, w_take, w_last;
`ifdef WB_BYTE_LOAD_EN
    logic              r_byte;
    load_extend #(.DATA_W(DATA_W)) u_ext (.i_byte(r_byte), .i_rdata(bus.dmem_rdata), .o_data(w_load));
`else
    assign w_load = bus.dmem_rdata;
`endif
    assign bus.in_ready         = r_state != WAIT_LOAD;
    assign w_xfer               = bus.in_valid & bus.in_ready;
    // rvalid wins over the timeout when both land in the same cycle
    assign w_take               = r_state == WAIT_LOAD & bus.dmem_rvalid;
    assign w_last               = r_state == WAIT_LOAD & ~bus.dmem_rvalid & r_cnt == LT_LAST;
    assign bus.RegWrite         = r_state == WRITE & r_we & r_rd != XZR;
    assign bus.WriteRegister    = r_rd;
    assign bus.WriteData        = r_data;
    assign bus.load_timeout_err = r_err;
    always_comb begin
        w_next = r_state;
        if (r_state == WAIT_LOAD)
            w_next = w_take ? WRITE : w_last ? IDLE : WAIT_LOAD;
        else
            w_next = w_xfer ? (bus.in_MemToReg ? WAIT_LOAD : WRITE) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`ifdef WB_BYTE_LOAD_EN
            r_byte  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_rd <= bus.in_Rd;
                r_we <= bus.in_RegWrite;
                if (!bus.in_MemToReg)
                    r_data <= bus.in_ALUResult;
                else
                    r_cnt <= '0;
`ifdef WB_BYTE_LOAD_EN
                if (bus.in_MemToReg)
                    r_byte <= bus.in_ByteLoad;
`endif
            end
            if (w_take)
                r_data <= w_load;
            if (w_last)
                r_err <= 1'b1;
            else if (r_state == WAIT_LOAD && !bus.dmem_rvalid)
                r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage
module tb_wb_stage;
    typedef struct {logic [4:0] rd; logic [63:0] d;} wr_t;
    logic clk = 1'b0;
    logic reset_n;
    int checks = 0;
    int failures = 0;
    int waited;
    wr_t sb[$];
    logic [63:0] regs [0:31];
    wb_stage_if bus ();
    wb_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] rf(input int r);
        return r == 31 ? 64'd0 : regs[r];
    endfunction
    // Scoreboard and register-file model: commit on the falling edge of a write cycle
    always @(negedge clk) begin
        if (bus.RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {63'd0, bus.RegWrite}, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_rd", {59'd0, bus.WriteRegister}, {59'd0, e.rd});
                chk("sb_data", bus.WriteData, e.d);
            end
            regs[bus.WriteRegister] = bus.WriteData;
        end
    end
    // Present one instruction at #1 after an edge; returns #1 after the accepting edge
    task automatic drive(input logic [4:0] rd, input logic we, input logic m2r,
                         input logic [63:0] alu, input logic bl, output int w);
        bus.in_Rd = rd;
        bus.in_RegWrite = we;
        bus.in_MemToReg = m2r;
        bus.in_ALUResult = alu;
        bus.in_ByteLoad = bl;
        bus.in_valid = 1'b1;
        w = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            w++;
        end
        if (w == 50) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [63:0] bexp;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset_n = 1'b0;
        bus.in_valid = 0; bus.in_RegWrite = 0; bus.in_MemToReg = 0; bus.in_Rd = '0;
        bus.in_ALUResult = '0; bus.in_ByteLoad = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        chk("rst_wreg", {59'd0, bus.WriteRegister}, 64'd0);
        chk("rst_wdata", bus.WriteData, 64'd0);
        chk("rst_err", {63'd0, bus.load_timeout_err}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        // ALU write to X3
        sb.push_back('{5'd3, 64'h1234});
        drive(5'd3, 1, 0, 64'h1234, 0, waited);
        bus.in_valid = 0;
        @(negedge clk);
        chk("alu_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        chk("alu_wreg", {59'd0, bus.WriteRegister}, 64'd3);
        chk("alu_wdata", bus.WriteData, 64'h1234);
        @(negedge clk);
        chk("alu_one_cycle", {63'd0, bus.RegWrite}, 64'd0);
        chk("x3_read", rf(3), 64'h1234);
        // Load to X5, rvalid sampled on the third edge
        @(posedge clk); #1;
        sb.push_back('{5'd5, 64'hDEADBEEF_CAFEF00D});
        drive(5'd5, 1, 1, 64'h0, 0, waited);
        bus.in_valid = 0;
        @(negedge clk); chk("ld_stall1", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("ld_stall2", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk); chk("ld_stall3", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        @(negedge clk);
        chk("ld_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        chk("ld_wdata", bus.WriteData, 64'hDEADBEEF_CAFEF00D);
        chk("ld_ready_in_write", {63'd0, bus.in_ready}, 64'd1);
        // Byte load to X6
        @(posedge clk); #1;
`ifdef WB_BYTE_LOAD_EN
        bexp = 64'h80;
`else
        bexp = 64'hFFFF_FFFF_FFFF_FF80;
`endif
        sb.push_back('{5'd6, bexp});
        drive(5'd6, 1, 1, 64'h0, 1, waited);
        bus.in_valid = 0;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FF80;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        @(negedge clk);
        chk("byte_wdata", bus.WriteData, bexp);
        // Write to X31 is suppressed
        @(posedge clk); #1;
        drive(5'd31, 1, 0, 64'h5555, 0, waited);
        bus.in_valid = 0;
        @(negedge clk);
        chk("xzr_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        chk("xzr_wreg", {59'd0, bus.WriteRegister}, 64'd31);
        @(negedge clk);
        chk("x31_read", rf(31), 64'd0);
        // rvalid arrives on the last allowed cycle: write wins, no error
        @(posedge clk); #1;
        sb.push_back('{5'd8, 64'hA5A5_0000_1111_2222});
        drive(5'd8, 1, 1, 64'h0, 0, waited);
        bus.in_valid = 0;
        repeat (14) @(posedge clk);
        #1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 64'hA5A5_0000_1111_2222;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        @(negedge clk);
        chk("edge_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        chk("edge_wreg", {59'd0, bus.WriteRegister}, 64'd8);
        chk("edge_err", {63'd0, bus.load_timeout_err}, 64'd0);
        // Load timeout to X7
        @(posedge clk); #1;
        drive(5'd7, 1, 1, 64'h0, 0, waited);
        bus.in_valid = 0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("to_still_wait", {63'd0, bus.in_ready}, 64'd0);
        chk("to_err_early", {63'd0, bus.load_timeout_err}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("to_err", {63'd0, bus.load_timeout_err}, 64'd1);
        chk("to_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("to_nowrite", {63'd0, bus.RegWrite}, 64'd0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 64'h1;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid", {63'd0, bus.RegWrite}, 64'd0);
        chk("err_sticky", {63'd0, bus.load_timeout_err}, 64'd1);
        // Three back-to-back ALU writes
        @(posedge clk); #1;
        sb.push_back('{5'd1, 64'h11});
        sb.push_back('{5'd2, 64'h22});
        sb.push_back('{5'd4, 64'h44});
        drive(5'd1, 1, 0, 64'h11, 0, waited);
        drive(5'd2, 1, 0, 64'h22, 0, waited);
        chk("b2b_wait2", waited, 64'd0);
        drive(5'd4, 1, 0, 64'h44, 0, waited);
        chk("b2b_wait3", waited, 64'd0);
        bus.in_valid = 0;
        @(negedge clk);
        chk("b2b_last", {59'd0, bus.WriteRegister}, 64'd4);
        chk("b2b_regwrite", {63'd0, bus.RegWrite}, 64'd1);
        @(negedge clk);
        chk("x1_read", rf(1), 64'h11);
        chk("x2_read", rf(2), 64'h22);
        chk("x4_read", rf(4), 64'h44);
        // Reset during WAIT_LOAD drops the write even with rvalid present
        @(posedge clk); #1;
        drive(5'd9, 1, 1, 64'h0, 0, waited);
        bus.in_valid = 0;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 64'h9999;
        reset_n = 0;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        @(negedge clk);
        chk("mrst_regwrite", {63'd0, bus.RegWrite}, 64'd0);
        chk("mrst_wreg", {59'd0, bus.WriteRegister}, 64'd0);
        chk("mrst_wdata", bus.WriteData, 64'd0);
        chk("mrst_err", {63'd0, bus.load_timeout_err}, 64'd0);
        chk("mrst_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
